// File: rtl/classificador_cores_quadrante_if.sv
// Bus between the colour classifier and its environment:
// start request, 3x3 sample-memory read port and face result.
interface classificador_cores_quadrante_if #(
  parameter int S_DATA = 16
);
  logic              iniciar;
  logic [S_DATA-1:0] pixel;
  logic [1:0]        addr_line;
  logic [1:0]        addr_column;
  logic              ocupado;
  logic              pronto;
  logic [26:0]       cores;

  modport master (
    output iniciar,
    output pixel,
    input  addr_line,
    input  addr_column,
    input  ocupado,
    input  pronto,
    input  cores
  );

  modport slave (
    input  iniciar,
    input  pixel,
    output addr_line,
    output addr_column,
    output ocupado,
    output pronto,
    output cores
  );
endinterface

// File: rtl/classificador_cores_quadrante.sv
// Walks the 3x3 RGB565 sample memory in row-major order and
// packs one 3-bit Rubik colour code per facelet into a face vector.
module classificador_cores_quadrante #(
  parameter int S_DATA       = 16,
  parameter int LIMIAR_ALTO  = 20,
  parameter int LIMIAR_MEDIO = 10,
  parameter int LIMIAR_BAIXO = 6
) (
  input logic clock,
  input logic reset,
  classificador_cores_quadrante_if.slave bus
);

  typedef enum logic [1:0] {
    OCIOSO,
    ENDERECA,
    CLASSIFICA,
    PRONTO
  } estado_t;

  localparam logic [4:0] ALTO  = 5'(LIMIAR_ALTO);
  localparam logic [4:0] MEDIO = 5'(LIMIAR_MEDIO);
  localparam logic [4:0] BAIXO = 5'(LIMIAR_BAIXO);

  estado_t     estado;
  estado_t     prox;
  logic [1:0]  line_q;
  logic [1:0]  col_q;
  logic [26:0] cores_q;
  logic [3:0]  slot;
  logic        ultimo;
  logic [4:0]  r5;
  logic [4:0]  g5;
  logic [4:0]  b5;
  logic [2:0]  codigo;

  // Green is reduced to 5 bits so all three channels share thresholds.
  assign r5 = bus.pixel[15:11];
  assign g5 = bus.pixel[10:6];
  assign b5 = bus.pixel[4:0];

  always_comb begin
    codigo = 3'b101;
    if (r5 < BAIXO && g5 < BAIXO && b5 < BAIXO)
      codigo = 3'b111;
    else if (r5 >= ALTO && g5 >= ALTO && b5 >= ALTO)
      codigo = 3'b000;
    else if (r5 >= ALTO && g5 >= ALTO)
      codigo = 3'b001;
    else if (r5 >= ALTO && g5 >= MEDIO)
      codigo = 3'b011;
    else if (r5 >= ALTO)
      codigo = 3'b010;
    else if (b5 > g5)
      codigo = 3'b100;
  end

  assign slot   = 4'(line_q) * 4'd3 + 4'(col_q);
  assign ultimo = (line_q == 2'd2) && (col_q == 2'd2);

  always_comb begin
    prox        = estado;
    bus.ocupado = 1'b0;
    bus.pronto  = 1'b0;
    unique case (estado)
      OCIOSO: begin
        if (bus.iniciar)
          prox = ENDERECA;
      end
      ENDERECA: begin
        bus.ocupado = 1'b1;
        prox        = CLASSIFICA;
      end
      CLASSIFICA: begin
        bus.ocupado = 1'b1;
        prox        = ultimo ? PRONTO : ENDERECA;
      end
      PRONTO: begin
        bus.pronto = 1'b1;
        prox       = OCIOSO;
      end
      default: prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado  <= OCIOSO;
      line_q  <= 2'd0;
      col_q   <= 2'd0;
      cores_q <= 27'd0;
    end else begin
      estado <= prox;
      if (estado == OCIOSO && bus.iniciar) begin
        line_q <= 2'd0;
        col_q  <= 2'd0;
      end
      if (estado == CLASSIFICA) begin
        for (int i = 0; i < 9; i++)
          if (slot == 4'(i))
            cores_q[3*i +: 3] <= codigo;
        if (!ultimo) begin
          if (col_q == 2'd2) begin
            col_q  <= 2'd0;
            line_q <= line_q + 2'd1;
          end else begin
            col_q <= col_q + 2'd1;
          end
        end
      end
    end
  end

  assign bus.addr_line   = line_q;
  assign bus.addr_column = col_q;
  assign bus.cores       = cores_q;

endmodule
